lcd_spi_capture: RTL and testbench

Receive-side counterpart of the LCD SPI serializer. Oversamples the 4-wire LCD SPI bus (sclk, data, dc, cs_n) in the mclk domain and deserializes it MSB-first into bytes tagged with D/C and start-of-frame. Bytes are buffered and presented on an AXI4-Stream master port. The block is used as an on-board loopback/monitor for verifying LCD traffic and as the capture front end for LCD-side read-back.

---
 rtl/lcd_spi_capture.sv | 222 ++++++++++++++++++++++
 tb/tb_lcd_spi_capture.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_spi_capture.sv
// LCD SPI capture: oversamples a mode-0 4-wire LCD bus into tagged bytes
// Ports: mclk/s00_axi_aresetn, enable, cnt_clear, lcd_* in, m_axis_* out, busy, counters
module lcd_spi_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        mclk,
  input  logic        s00_axi_aresetn,
  input  logic        enable,
  input  logic        cnt_clear,
  input  logic        lcd_sclk,
  input  logic        lcd_data,
  input  logic        lcd_dc,
  input  logic        lcd_cs_n,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic [1:0]  m_axis_tuser,
  output logic        busy,
  output logic [15:0] byte_count,
  output logic [7:0]  frame_err_count,
  output logic [7:0]  overflow_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  // Asynchronous assert, release aligned to mclk
  logic [1:0] rst_q;
  logic       rst_n;

  always_ff @(posedge mclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) rst_q <= '0;
    else                  rst_q <= {rst_q[0], 1'b1};
  end

  assign rst_n = rst_q[1];

  logic [SYNC_STAGES-1:0] sclk_sy;
  logic [SYNC_STAGES-1:0] data_sy;
  logic [SYNC_STAGES-1:0] dc_sy;
  logic [SYNC_STAGES-1:0] cs_sy;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sy <= '0;
      data_sy <= '0;
      dc_sy   <= '0;
      cs_sy   <= '1;
    end else begin
      sclk_sy <= {sclk_sy[SYNC_STAGES-2:0], lcd_sclk};
      data_sy <= {data_sy[SYNC_STAGES-2:0], lcd_data};
      dc_sy   <= {dc_sy[SYNC_STAGES-2:0], lcd_dc};
      cs_sy   <= {cs_sy[SYNC_STAGES-2:0], lcd_cs_n};
    end
  end

  logic s_sclk, s_data, s_dc, s_cs;

  assign s_sclk = sclk_sy[SYNC_STAGES-1];
  assign s_data = data_sy[SYNC_STAGES-1];
  assign s_dc   = dc_sy[SYNC_STAGES-1];
  assign s_cs   = cs_sy[SYNC_STAGES-1];

  logic sclk_d, cs_d;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sclk_d <= s_sclk;
      cs_d   <= s_cs;
    end
  end

  logic sclk_rise, cs_fall, cs_rise;

  assign sclk_rise = s_sclk & ~sclk_d;
  assign cs_fall   = cs_d & ~s_cs;
  assign cs_rise   = ~cs_d & s_cs;
  assign busy      = ~s_cs;

  state_t     state_q, state_n;
  logic [2:0] bit_cnt;
  logic       bit_evt, byte_evt, frame_evt;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n   = state_q;
    bit_evt   = 1'b0;
    byte_evt  = 1'b0;
    frame_evt = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall && enable) state_n = SHIFT;
      end
      SHIFT: begin
        if (!enable) begin
          state_n = IDLE;
        end else if (cs_rise) begin
          state_n   = IDLE;
          frame_evt = (bit_cnt != 3'd0);
        end else if (sclk_rise) begin
          bit_evt  = 1'b1;
          byte_evt = (bit_cnt == 3'd7);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  logic [6:0] shift_q;
  logic [7:0] byte_q;
  logic       dc_q;
  logic       byte_done;
  logic       sof_pending;
  logic       push_req;
  logic [9:0] push_word;

  // Byte forms at the 8th rise; it is offered to the FIFO one cycle later
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      shift_q     <= '0;
      byte_q      <= '0;
      dc_q        <= 1'b0;
      byte_done   <= 1'b0;
      sof_pending <= 1'b0;
      push_req    <= 1'b0;
      push_word   <= '0;
    end else begin
      byte_done <= byte_evt;
      push_req  <= byte_done;
      if (state_q != SHIFT || state_n != SHIFT) begin
        bit_cnt <= '0;
      end else if (bit_evt) begin
        bit_cnt <= bit_cnt + 3'd1;
        shift_q <= {shift_q[5:0], s_data};
      end
      if (byte_evt) begin
        byte_q <= {shift_q, s_data};
        dc_q   <= s_dc;
      end
      if (byte_done) push_word <= {sof_pending, dc_q, byte_q};
      if (state_q == IDLE && state_n == SHIFT) sof_pending <= 1'b1;
      else if (byte_done)                      sof_pending <= 1'b0;
    end
  end

  // FIFO: storage array plus a registered output slot; both count toward depth
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] mem_cnt;
  logic [CW-1:0] occ;
  logic          out_valid;
  logic [7:0]    out_data;
  logic [1:0]    out_user;
  logic          pop, load, room, wr, drop;

  assign pop  = out_valid & m_axis_tready;
  assign load = (mem_cnt != '0) && (!out_valid || pop);
  assign occ  = mem_cnt + CW'(out_valid);
  assign room = (occ != CW'(FIFO_DEPTH)) || pop;
  assign wr   = push_req & room;
  assign drop = push_req & ~room;

  always_ff @(posedge mclk) begin
    if (wr) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_user  <= '0;
    end else begin
      mem_cnt <= mem_cnt + CW'(wr) - CW'(load);
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= mem[rd_ptr][7:0];
        out_user  <= mem[rd_ptr][9:8];
        rd_ptr    <= rd_ptr + 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign m_axis_tvalid = out_valid;
  assign m_axis_tdata  = out_data;
  assign m_axis_tuser  = out_user;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      byte_count      <= '0;
      frame_err_count <= '0;
      overflow_count  <= '0;
    end else if (cnt_clear) begin
      byte_count      <= '0;
      frame_err_count <= '0;
      overflow_count  <= '0;
    end else begin
      if (wr) byte_count <= byte_count + 16'd1;
      if (drop && overflow_count != 8'hFF)
        overflow_count <= overflow_count + 8'd1;
      if (frame_evt && frame_err_count != 8'hFF)
        frame_err_count <= frame_err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_lcd_spi_capture.sv
// Bench for lcd_spi_capture: directed frames with random payloads
// checked against a byte-level queue model of the captured stream.
module tb_lcd_spi_capture;

  localparam int S = 2;
  localparam int D = 16;

  logic        mclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        cnt_clear = 1'b0;
  logic        lcd_sclk = 1'b0;
  logic        lcd_data = 1'b0;
  logic        lcd_dc = 1'b0;
  logic        lcd_cs_n = 1'b1;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic [1:0]  m_axis_tuser;
  logic        busy;
  logic [15:0] byte_count;
  logic [7:0]  frame_err_count;
  logic [7:0]  overflow_count;

  lcd_spi_capture #(.SYNC_STAGES(S), .FIFO_DEPTH(D)) dut (
    .mclk            (mclk),
    .s00_axi_aresetn (rst_n),
    .enable          (enable),
    .cnt_clear       (cnt_clear),
    .lcd_sclk        (lcd_sclk),
    .lcd_data        (lcd_data),
    .lcd_dc          (lcd_dc),
    .lcd_cs_n        (lcd_cs_n),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tuser    (m_axis_tuser),
    .busy            (busy),
    .byte_count      (byte_count),
    .frame_err_count (frame_err_count),
    .overflow_count  (overflow_count)
  );

  always #5 mclk = ~mclk;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q[$];
  int         m_bytes = 0;
  int         m_ferr = 0;
  int         m_ovf = 0;
  logic       m_sof = 1'b0;
  int         rmode = 1;
  int         rcyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Downstream ready: 0 = stalled, 1 = always, 2 = one cycle in three
  initial begin
    forever begin
      @(posedge mclk);
      #1;
      case (rmode)
        0:       m_axis_tready = 1'b0;
        1:       m_axis_tready = 1'b1;
        default: m_axis_tready = (rcyc % 3 == 0);
      endcase
      rcyc++;
    end
  end

  // Every visible output word must be the oldest expected byte
  always @(negedge mclk) begin
    if (rst_n && m_axis_tvalid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'(m_axis_tvalid), 32'd0);
      end else begin
        chk("tdata", 32'(m_axis_tdata), 32'(exp_q[0][7:0]));
        chk("tuser", 32'(m_axis_tuser), 32'(exp_q[0][9:8]));
        if (m_axis_tready) void'(exp_q.pop_front());
      end
    end
  end

  function automatic void model_byte(input logic [7:0] b, input logic d);
    if (exp_q.size() < D) begin
      exp_q.push_back({m_sof, d, b});
      m_bytes = (m_bytes + 1) % 65536;
    end else if (m_ovf < 255) begin
      m_ovf++;
    end
    m_sof = 1'b0;
  endfunction

  function automatic void model_clear();
    m_bytes = 0;
    m_ferr = 0;
    m_ovf = 0;
  endfunction

  task automatic frame_start();
    lcd_sclk = 1'b0;
    lcd_cs_n = 1'b0;
    m_sof = 1'b1;
    repeat (4) @(negedge mclk);
  endtask

  task automatic frame_end();
    lcd_sclk = 1'b0;
    repeat (2) @(negedge mclk);
    lcd_cs_n = 1'b1;
    repeat (4) @(negedge mclk);
  endtask

  // mode 1: check output latency; mode 2: clear lands on the push cycle
  task automatic send_byte(input logic [7:0] b, input logic d,
                           input int mode);
    lcd_dc = d;
    for (int i = 7; i >= 0; i--) begin
      lcd_sclk = 1'b0;
      lcd_data = b[i];
      repeat (2) @(negedge mclk);
      lcd_sclk = 1'b1;
      if (i == 0) begin
        model_byte(b, d);
        if (mode == 1) begin
          repeat (S + 3) @(negedge mclk);
          chk("lat_before", 32'(m_axis_tvalid), 32'd0);
          @(negedge mclk);
          chk("lat_at", 32'(m_axis_tvalid), 32'd1);
        end else if (mode == 2) begin
          repeat (S + 2) @(negedge mclk);
          cnt_clear = 1'b1;
          model_clear();
          @(negedge mclk);
          cnt_clear = 1'b0;
          @(negedge mclk);
        end else begin
          repeat (2) @(negedge mclk);
        end
      end else begin
        repeat (2) @(negedge mclk);
      end
    end
  endtask

  task automatic send_bits(input int n, input logic v);
    for (int i = 0; i < n; i++) begin
      lcd_sclk = 1'b0;
      lcd_data = v;
      repeat (2) @(negedge mclk);
      lcd_sclk = 1'b1;
      repeat (2) @(negedge mclk);
    end
    lcd_sclk = 1'b0;
    repeat (2) @(negedge mclk);
  endtask

  task automatic abort_frame(input int n);
    frame_start();
    send_bits(n, 1'b1);
    lcd_cs_n = 1'b1;
    repeat (4) @(negedge mclk);
    if (n > 0 && n < 8 && m_ferr < 255) m_ferr++;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge mclk);
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_clear();
    cnt_clear = 1'b1;
    model_clear();
    @(negedge mclk);
    cnt_clear = 1'b0;
    @(negedge mclk);
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_bytes"}, 32'(byte_count), 32'(m_bytes));
    chk({tag, "_ferr"}, 32'(frame_err_count), 32'(m_ferr));
    chk({tag, "_ovf"}, 32'(overflow_count), 32'(m_ovf));
  endtask

  logic [7:0] rb;
  logic       rd;

  initial begin
    rmode = 1;
    repeat (3) @(negedge mclk);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
    chk("rst_tuser", 32'(m_axis_tuser), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk_counters("rst");
    rst_n = 1'b1;
    repeat (5) @(negedge mclk);

    // Basic mode-0 frame with output latency measurement
    frame_start();
    chk("busy_low_cs", 32'(busy), 32'd1);
    send_byte(8'h2A, 1'b0, 1);
    send_byte(8'hA5, 1'b1, 0);
    send_byte(8'h3C, 1'b1, 0);
    frame_end();
    chk("busy_idle", 32'(busy), 32'd0);
    drain("drain_basic");
    chk_counters("basic");

    // Partial byte aborted by cs_n rise, then a clean byte
    abort_frame(5);
    frame_start();
    send_byte(8'h11, 1'b1, 0);
    frame_end();
    drain("drain_abort");
    chk_counters("abort");

    // Overflow with downstream stalled
    rmode = 0;
    @(negedge mclk);
    frame_start();
    for (int i = 0; i < D + 3; i++) send_byte(8'(i), 1'b0, 0);
    frame_end();
    chk_counters("ovf");
    chk("ovf_held", 32'(exp_q.size()), 32'(D));
    rmode = 1;
    drain("drain_ovf");
    repeat (40) @(negedge mclk);
    chk("ovf_empty", 32'(m_axis_tvalid), 32'd0);

    // 64 random bytes under 1-in-3 backpressure
    pulse_clear();
    rmode = 2;
    frame_start();
    for (int i = 0; i < 64; i++) begin
      rb = 8'($urandom);
      rd = 1'($urandom);
      send_byte(rb, rd, 0);
    end
    frame_end();
    drain("drain_bp");
    chk_counters("bp");
    rmode = 1;

    // Counter clear coinciding with an overflow drop
    pulse_clear();
    rmode = 0;
    @(negedge mclk);
    frame_start();
    for (int i = 0; i < D; i++) send_byte(8'($urandom), 1'b1, 0);
    send_byte(8'hEE, 1'b0, 2);
    chk_counters("clr_coinc");
    send_byte(8'hEF, 1'b0, 0);
    frame_end();
    chk_counters("clr_after");
    rmode = 1;
    drain("drain_clr");

    // Frame error saturation
    pulse_clear();
    for (int i = 0; i < 260; i++) abort_frame(1 + (i % 7));
    chk_counters("sat");

    // Asynchronous reset mid-byte with a queued backlog
    rmode = 0;
    @(negedge mclk);
    frame_start();
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0, 0);
    send_bits(3, 1'b1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    model_clear();
    m_sof = 1'b0;
    #1;
    chk("arst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk_counters("arst");
    lcd_cs_n = 1'b1;
    lcd_sclk = 1'b0;
    repeat (3) @(negedge mclk);
    rst_n = 1'b1;
    repeat (6) @(negedge mclk);
    chk("post_rst_valid", 32'(m_axis_tvalid), 32'd0);
    rmode = 1;
    frame_start();
    rd = 1'($urandom);
    send_byte(8'h5A, rd, 0);
    frame_end();
    drain("drain_post_rst");
    chk_counters("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
